// File: rtl/tri_sched_pkg.sv
// Shared types and default sizing for the triangle-check scheduler.
package tri_sched_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int W_DEF         = 3;
  localparam int TO_CYCLES_DEF = 8;

  typedef enum logic [2:0] {
    ARB    = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    SEND_C = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/tri_check_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request after last_grant, wrapping modulo NREQ.
module rr_arbiter
  import tri_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    // Offset 1 first so the previous winner has lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(last_grant) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
      end
    end
  end

endmodule

// File: rtl/tri_check_sched.sv
// Shares one serial triangle-check engine among NREQ requesters (round-robin).
// Optional engine-response timeout enabled by defining TRI_SCHED_TIMEOUT_EN.
module tri_check_sched
  import tri_sched_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int W         = W_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_result,
  output logic              rsp_err,
  output logic              eng_in_valid,
  output logic [W-1:0]      eng_input,
  input  logic              eng_out,
  input  logic              eng_out_valid
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [IW-1:0]     r_last_grant;
  logic [IW-1:0]     r_grant_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_c;
  logic              r_result;
  logic [NREQ-1:0]   w_arb_grant;
  logic [IW-1:0]     w_arb_idx;
  logic              w_any;

  assign w_any = |req_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_arb_grant),
    .grant_idx  (w_arb_idx)
  );

`ifdef TRI_SCHED_TIMEOUT_EN
  localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [CW-1:0] r_to_cnt;
  logic          r_err;
  logic          w_timeout;

  assign w_timeout = (r_to_cnt == CW'(TO_CYCLES - 1));

  // Counter restarts as WAIT is entered, so it measures WAIT cycles only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == SEND_C) begin
        r_to_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (r_state == WAIT) begin
        if (eng_out_valid) begin
          r_err <= 1'b0;
        end else if (w_timeout) begin
          r_err <= 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_result   = 1'b0;
    rsp_err      = 1'b0;
    eng_in_valid = 1'b0;
    eng_input    = '0;
    case (r_state)
      ARB: begin
        if (w_any) begin
          w_state_next = SEND_A;
          if (!RST) begin
            req_ready = w_arb_grant;
          end
        end
      end
      SEND_A: begin
        eng_in_valid = 1'b1;
        eng_input    = r_a;
        w_state_next = SEND_B;
      end
      SEND_B: begin
        eng_input    = r_b;
        w_state_next = SEND_C;
      end
      SEND_C: begin
        eng_input    = r_c;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (eng_out_valid) begin
          w_state_next = RESP;
        end
`ifdef TRI_SCHED_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_next = RESP;
        end
`endif
      end
      RESP: begin
        rsp_valid    = NREQ'(1) << r_grant_idx;
        rsp_result   = r_result;
`ifdef TRI_SCHED_TIMEOUT_EN
        rsp_err      = r_err;
`endif
        w_state_next = ARB;
      end
      default: begin
        w_state_next = ARB;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ARB;
      r_last_grant <= IW'(NREQ - 1);
      r_grant_idx  <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_result     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ARB && w_any) begin
        r_grant_idx <= w_arb_idx;
        r_a         <= req_a[w_arb_idx*W +: W];
        r_b         <= req_b[w_arb_idx*W +: W];
        r_c         <= req_c[w_arb_idx*W +: W];
      end
      if (r_state == WAIT && eng_out_valid) begin
        r_result <= eng_out;
      end
`ifdef TRI_SCHED_TIMEOUT_EN
      else if (r_state == WAIT && w_timeout) begin
        r_result <= 1'b0;
      end
`endif
      if (r_state == RESP) begin
        r_last_grant <= r_grant_idx;
      end
    end
  end

endmodule

// File: doc/tri_check_sched.md
TRI_CHECK_SCHED -- requirements
Module: tri_check_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one triangle-check engine.
REQ-002 The block SHALL have parameter W, default 3, giving the side width in bits.
REQ-003 The block SHALL have parameter TO_CYCLES, default 8, giving the engine-response timeout in cycles, used only under the timeout feature.
REQ-004 The block SHALL have port CLK, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: per-requester request pending.
REQ-007 The block SHALL have ports req_a, req_b and req_c, inputs, NREQ*W bits each: packed side values, requester i in bits [i*W +: W].
REQ-008 The block SHALL have port req_ready, output, NREQ bits: one-hot accept pulse.
REQ-009 The block SHALL have port rsp_valid, output, NREQ bits: one-hot result pulse to the granted requester.
REQ-010 The block SHALL have port rsp_result, output, 1 bit: 1 means the sides form a valid triangle.
REQ-011 The block SHALL have port rsp_err, output, 1 bit: the engine timed out.
REQ-012 The block SHALL have ports eng_in_valid (output, 1 bit) and eng_input (output, W bits): serial side stream to the engine.
REQ-013 The block SHALL have ports eng_out (input, 1 bit) and eng_out_valid (input, 1 bit): engine result and its one-cycle valid.

Function
REQ-014 The FSM SHALL have states ARB, SEND_A, SEND_B, SEND_C, WAIT and RESP.
REQ-015 ARB with any req_valid set: grant g = first set bit searching from last_grant+1 modulo NREQ; capture req_a/b/c[g]; req_ready[g]=1 this cycle (combinational from state and grant); next state SEND_A.
REQ-016 ARB with no req_valid set: stay in ARB; req_ready=0.
REQ-017 SEND_A: eng_in_valid=1, eng_input=a. SEND_B: eng_in_valid=0, eng_input=b. SEND_C: eng_in_valid=0, eng_input=c. Each of these states SHALL last exactly one cycle.
REQ-018 Outside the SEND states, eng_input SHALL be 0; eng_in_valid SHALL be high only in SEND_A.
REQ-019 WAIT: on eng_out_valid=1, latch eng_out into the result register and go to RESP; otherwise remain in WAIT.
REQ-020 RESP: rsp_valid[g]=1 and rsp_result/rsp_err driven for exactly one cycle; next state ARB; last_grant<=g.
REQ-021 With a nominal engine (result valid 4 cycles after its first side), an accept in cycle t SHALL give rsp_valid in cycle t+6 and the next accept no earlier than t+7.
REQ-022 eng_out_valid in any state other than WAIT SHALL be ignored.
REQ-023 A requester SHALL hold its req_valid and sides stable until req_ready; dropping req_valid before grant is legal; a requester that never asserts req_valid is never granted.
REQ-024 Side values SHALL be passed unmodified; the block performs no arithmetic on sides.

Reset
REQ-025 RST SHALL set the state to ARB and last_grant to NREQ-1, so requester 0 has first priority.
REQ-026 RST SHALL set all outputs to 0 and clear any in-flight request without a response; this applies to reset in any state, including mid-SEND and WAIT.
REQ-027 The engine SHALL share RST, so both sides restart idle together.

Configuration
REQ-028 With TRI_SCHED_TIMEOUT_EN defined, a WAIT counter SHALL run; if TO_CYCLES cycles elapse in WAIT without eng_out_valid, the block SHALL enter RESP with rsp_err=1 and rsp_result=0, and the counter SHALL clear on entry to WAIT.
REQ-029 Without TRI_SCHED_TIMEOUT_EN, WAIT SHALL persist indefinitely, rsp_err SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-030 Package tri_sched_pkg SHALL hold the state typedef and the default constants for NREQ, W and TO_CYCLES.
REQ-031 Round-robin grant logic SHALL be the sub-module rr_arbiter (inputs req and last_grant; outputs one-hot grant and index).

Verification
REQ-032 Single request, req_valid=0001 with sides (3,4,5): eng_input sequence 3,4,5 with eng_in_valid on the first only; rsp_valid=0001, rsp_result=1 at t+6.
REQ-033 Degenerate triangle (1,2,3): rsp_result=0; and (0,0,0): rsp_result=0.
REQ-034 All four requesters held continuously: grants in order 0,1,2,3,0 at 7-cycle spacing; each rsp_valid goes only to its own requester.
REQ-035 RST asserted during SEND_B: the next cycle shows ARB, all outputs 0, and no rsp_valid for the aborted request.
REQ-036 With TRI_SCHED_TIMEOUT_EN, engine held silent: rsp_err=1 and rsp_result=0 after 8 WAIT cycles; without the macro the block stays in WAIT; a stray eng_out_valid in ARB has no effect.
